// File: rtl/nibble_packer.sv
// Packs 4-bit nibbles into bytes and queues them in a DEPTH-entry FIFO.
// Define NIBBLE_PACKER_LAST_EN to honour in_last (partial bytes, last/partial flags).
module nibble_packer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_nib,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_byte,
  output logic                     out_last,
  output logic                     out_partial,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {EMPTY, HALF} state_t;

  state_t        state_q, state_d;
  logic [3:0]    held_q, held_d;
  logic          push, pop, in_xfer, last_c;
  logic [7:0]    push_byte;
  logic          push_last, push_partial;
  logic [CW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    mem_byte [DEPTH];

`ifdef NIBBLE_PACKER_LAST_EN
  assign last_c = in_last;
`else
  logic unused_last;
  assign unused_last = in_last;
  assign last_c      = 1'b0;
`endif

  assign count     = wr_ptr - rd_ptr;
  assign in_ready  = rst_n & (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign in_xfer   = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Packing FSM state and held low nibble
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    held_d       = held_q;
    push         = 1'b0;
    push_byte    = '0;
    push_last    = 1'b0;
    push_partial = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          if (last_c) begin
            // Lone trailing nibble is zero-extended into a partial byte
            push         = 1'b1;
            push_byte    = {4'b0000, in_nib};
            push_last    = 1'b1;
            push_partial = 1'b1;
          end else begin
            held_d  = in_nib;
            state_d = HALF;
          end
        end
      end
      HALF: begin
        if (in_xfer) begin
          push      = 1'b1;
          push_byte = {in_nib, held_q};
          push_last = last_c;
          state_d   = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Pointers carry a wrap bit so full and empty are distinguishable
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + CW'(1);
      if (pop)  rd_ptr <= rd_ptr + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_byte[wr_ptr[AW-1:0]] <= push_byte;
  end

  assign out_byte = out_valid ? mem_byte[rd_ptr[AW-1:0]] : 8'h00;

`ifdef NIBBLE_PACKER_LAST_EN
  logic mem_last    [DEPTH];
  logic mem_partial [DEPTH];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_last[wr_ptr[AW-1:0]]    <= push_last;
      mem_partial[wr_ptr[AW-1:0]] <= push_partial;
    end
  end

  assign out_last    = out_valid & mem_last[rd_ptr[AW-1:0]];
  assign out_partial = out_valid & mem_partial[rd_ptr[AW-1:0]];
`else
  logic unused_flags;
  assign unused_flags = push_last | push_partial;
  assign out_last     = 1'b0;
  assign out_partial  = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_packer.sv
// Directed self-checking bench for nibble_packer (DEPTH=4).
// Last/partial checks follow whether NIBBLE_PACKER_LAST_EN is defined.
module tb_nibble_packer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_last;
  logic [3:0] in_nib;
  logic       out_valid, out_ready, out_last, out_partial;
  logic [7:0] out_byte;
  logic [2:0] count;

  int n_checks = 0;
  int n_errors = 0;

  nibble_packer #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_nib(in_nib), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .out_last(out_last), .out_partial(out_partial), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] nib, input logic last);
    in_valid = 1'b1;
    in_nib   = nib;
    in_last  = last;
    cyc();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  logic [7:0] q[$];
  logic [7:0] drain_exp[3];
  int         idx, npop, sz0;
  logic       half, acc;
  logic [3:0] held;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_nib = '0; in_last = 1'b0; out_ready = 1'b0;
    cyc(); cyc();
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_byte", 32'(out_byte), 0);
    check("rst_count", 32'(count), 0);
    check("rst_flags", 32'({out_last, out_partial}), 0);

    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 1);

    // Basic pair 0x3, 0xA -> 0xA3 for exactly one cycle
    out_ready = 1'b1;
    send(4'h3, 1'b0);
    check("pair_no_early", 32'(out_valid), 0);
    send(4'hA, 1'b0);
    check("pair_valid", 32'(out_valid), 1);
    check("pair_byte", 32'(out_byte), 32'h0A3);
    cyc();
    check("pair_one_cycle", 32'(out_valid), 0);
    check("pair_count", 32'(count), 0);

`ifdef NIBBLE_PACKER_LAST_EN
    send(4'h7, 1'b1);
    check("part_byte", 32'(out_byte), 32'h07);
    check("part_flags", 32'({out_last, out_partial}), 32'b10 + 32'b01);
    cyc();
    send(4'h1, 1'b0);
    send(4'h2, 1'b1);
    check("last_byte", 32'(out_byte), 32'h21);
    check("last_flags", 32'({out_last, out_partial}), 32'b10);
    cyc();
`else
    send(4'h9, 1'b1);
    check("nolast_no_partial", 32'(out_valid), 0);
    send(4'h4, 1'b0);
    check("nolast_byte", 32'(out_byte), 32'h49);
    check("nolast_flags", 32'({out_last, out_partial}), 0);
    cyc();
    check("nolast_single", 32'(out_valid), 0);
`endif

    // Fill with out_ready low: bytes 0x10 0x32 0x54 0x76
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(4'(i), 1'b0);
    check("full_count", 32'(count), 4);
    check("full_in_ready", 32'(in_ready), 0);
    check("full_head", 32'(out_byte), 32'h10);
    in_valid = 1'b1; in_nib = 4'hF;
    cyc(); cyc();
    in_valid = 1'b0;
    check("full_stable_byte", 32'(out_byte), 32'h10);
    check("full_stable_count", 32'(count), 4);
    out_ready = 1'b1;
    cyc();
    check("full_ready_back", 32'(in_ready), 1);
    check("full_count_after_pop", 32'(count), 3);
    drain_exp[0] = 8'h32; drain_exp[1] = 8'h54; drain_exp[2] = 8'h76;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("drain_%0d", k), 32'(out_byte), 32'(drain_exp[k]));
      cyc();
    end
    check("drain_empty", 32'(count), 0);

    // Continuous input, out_ready toggling, queue-model scoreboard
    q.delete(); idx = 0; npop = 0; half = 1'b0; held = '0;
    for (int c = 0; c < 80; c++) begin
      out_ready = c[0];
      in_valid  = (idx < 16);
      in_nib    = 4'(idx);
      in_last   = 1'b0;
      #1;
      sz0 = q.size();
      check("tog_count", 32'(count), 32'(sz0));
      check("tog_in_ready", 32'(in_ready), 32'(sz0 != 4));
      check("tog_valid", 32'(out_valid), 32'(sz0 != 0));
      if (sz0 != 0) check("tog_byte", 32'(out_byte), 32'(q[0]));
      acc = in_valid && (sz0 != 4);
      if (out_ready && sz0 != 0) begin
        void'(q.pop_front());
        npop++;
      end
      if (acc) begin
        if (half) q.push_back({in_nib, held});
        else      held = in_nib;
        half = ~half;
        idx++;
      end
      cyc();
      if (idx == 16 && q.size() == 0) break;
    end
    in_valid = 1'b0;
    check("tog_all_sent", 32'(idx), 16);
    check("tog_all_popped", 32'(npop), 8);
    check("tog_end_count", 32'(count), 0);

    // Reset while HALF with two bytes queued
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(4'(i), 1'b0);
    check("mid_count", 32'(count), 2);
    rst_n = 1'b0; in_valid = 1'b1; in_nib = 4'hF;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 0);
    cyc();
    rst_n = 1'b1; in_valid = 1'b0;
    check("mid_out_valid", 32'(out_valid), 0);
    check("mid_count_clr", 32'(count), 0);
    check("mid_byte_clr", 32'(out_byte), 0);
    out_ready = 1'b1;
    send(4'h5, 1'b0);
    check("mid_no_stale", 32'(out_valid), 0);
    send(4'h6, 1'b0);
    check("mid_pair_byte", 32'(out_byte), 32'h65);
    cyc();
    check("mid_final_count", 32'(count), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
